// File: rtl/stream_arb4x1_if.sv
// Purpose: stream bundle between four requesters and one downstream consumer.
// Latency: none, wiring only.
// Backpressure: valid/ready on every requester lane and on the output.
interface stream_arb4x1_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            in_valid;
  logic [DATA_WIDTH-1:0] in_data [4];
  logic [3:0]            in_last;
  logic [3:0]            in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  // Source side: drives the requester lanes and the downstream ready.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_arb4x1.sv
// Purpose: 4:1 round-robin packet arbiter with per-packet beat watchdog.
// Latency: one cycle from accepted input beat to registered output beat.
// Backpressure: in_ready of the granted lane follows (!out_valid || out_ready); no bubble on a full pipe.
module stream_arb4x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_arb4x1_if.slave bus,
  input  logic [3:0]     req_mask,
  output logic [1:0]     grant_sel,
  output logic           busy,
  output logic           timeout
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [1:0]            rr_ptr, rr_nxt;
  logic [1:0]            grant_nxt;
  logic [CNT_W-1:0]      beat_cnt, cnt_nxt;
  logic                  timeout_nxt;
  logic [3:0]            eligible;
  logic [1:0]            cand;
  logic [1:0]            win_idx;
  logic                  win_found;
  logic [3:0]            ready_vec;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;

  assign sel_data      = bus.in_data[grant_sel];
  assign sel_last      = bus.in_last[grant_sel];
  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state == BUSY);

  // Round-robin search: start one past the last served requester and wrap.
  always_comb begin
    eligible  = bus.in_valid & ~req_mask;
    cand      = 2'd0;
    win_idx   = 2'd0;
    win_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, handshake and watchdog decisions.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_sel;
    rr_nxt      = rr_ptr;
    cnt_nxt     = beat_cnt;
    timeout_nxt = 1'b0;
    ready_vec   = 4'b0000;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        // Mask only gates new grants; it is sampled here and nowhere else.
        if (win_found) begin
          state_nxt = BUSY;
          grant_nxt = win_idx;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        ready_vec[grant_sel] = !out_valid_q || bus.out_ready;
        accept               = bus.in_valid[grant_sel] && ready_vec[grant_sel];
        if (accept) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (sel_last) begin
            state_nxt = IDLE;
            rr_nxt    = grant_sel;
          end else if (cnt_nxt == CNT_W'(MAX_BEATS)) begin
            // Runaway packet: release the grant, beats already taken stay in flight.
            state_nxt   = IDLE;
            rr_nxt      = grant_sel;
            timeout_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers; rr_ptr resets to 3 so the first search begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_sel <= 2'd0;
      rr_ptr    <= 2'd3;
      beat_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_sel <= grant_nxt;
      rr_ptr    <= rr_nxt;
      beat_cnt  <= cnt_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Output register: reload on accept (even while draining), otherwise clear valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb4x1.sv
// Purpose: directed checks of stream_arb4x1 arbitration, stall, mask, watchdog and reset.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: out_ready driven per vector to exercise stalls.
module tb_stream_arb4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_mask;
  logic [1:0] grant_sel;
  logic       busy;
  logic       timeout;
  int         checks   = 0;
  int         failures = 0;

  stream_arb4x1_if #(.DATA_WIDTH(32)) bus ();

  stream_arb4x1 #(.DATA_WIDTH(32), .MAX_BEATS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .req_mask  (req_mask),
    .grant_sel (grant_sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [3:0]  msk;
    logic        ordy;
    logic [7:0]  dat;
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] od;
    logic        ol;
    logic [1:0]  gnt;
    logic        bsy;
    logic        to;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lane i carries its index in bits 11:8 and the beat tag in bits 7:0.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic ordy, input logic [7:0] dat);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    for (int i = 0; i < 4; i++) bus.in_data[i] = 32'(i * 256) + 32'(dat);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [31:0] od, input logic ol,
                         input logic [1:0] g, input logic b, input logic to);
    chk({nm, "_ov"}, 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk({nm, "_od"}, bus.out_data, od);
      chk({nm, "_ol"}, 32'(bus.out_last), 32'(ol));
    end
    chk({nm, "_gnt"}, 32'(grant_sel), 32'(g));
    chk({nm, "_busy"}, 32'(busy), 32'(b));
    chk({nm, "_to"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    // Round robin over all four lanes, 2-beat packets, then single-beat packets on lanes 1 and 3.
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd1, 4'h1, 1'b1, 32'h001, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'hF, 4'hF, 4'h0, 1'b1, 8'd2, 4'h1, 1'b1, 32'h002, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd1, 4'h2, 1'b1, 32'h101, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{4'hF, 4'hF, 4'h0, 1'b1, 8'd2, 4'h2, 1'b1, 32'h102, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[7]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd1, 4'h4, 1'b1, 32'h201, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{4'hF, 4'hF, 4'h0, 1'b1, 8'd2, 4'h4, 1'b1, 32'h202, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd1, 4'h8, 1'b1, 32'h301, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{4'hF, 4'hF, 4'h0, 1'b1, 8'd2, 4'h8, 1'b1, 32'h302, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[12] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[13] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'd1, 4'h1, 1'b1, 32'h001, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[14] = '{4'hF, 4'hF, 4'h0, 1'b1, 8'd2, 4'h1, 1'b1, 32'h002, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[16] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd5, 4'h2, 1'b1, 32'h105, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[17] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[18] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd6, 4'h8, 1'b1, 32'h306, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[19] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[20] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd7, 4'h2, 1'b1, 32'h107, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[21] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd0, 4'h0, 1'b0, 32'h000, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[22] = '{4'hA, 4'hF, 4'h0, 1'b1, 8'd8, 4'h8, 1'b1, 32'h308, 1'b1, 2'd3, 1'b0, 1'b0};

    rst_n    = 1'b0;
    req_mask = 4'h0;
    drive(4'h0, 4'h0, 1'b1, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_od", bus.out_data, 32'd0);
    chk("rst_ol", 32'(bus.out_last), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_gnt", 32'(grant_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      req_mask = tbl[k].msk;
      drive(tbl[k].vld, tbl[k].lst, tbl[k].ordy, tbl[k].dat);
      #1 chk($sformatf("v%0d_rdy", k), 32'(bus.in_ready), 32'(tbl[k].rdy));
      tick();
      chk_out($sformatf("v%0d", k), tbl[k].ov, tbl[k].od, tbl[k].ol, tbl[k].gnt, tbl[k].bsy, tbl[k].to);
    end

    // Mask: lane 0 excluded, lane 1 wins; mask flips to lane 1 mid-packet without revoking it.
    req_mask = 4'b0001;
    drive(4'b0011, 4'h0, 1'b1, 8'd1);
    tick();
    chk_out("m_arb", 1'b0, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0);
    drive(4'b0011, 4'h0, 1'b1, 8'd1);
    tick();
    chk_out("m_b1", 1'b1, 32'h101, 1'b0, 2'd1, 1'b1, 1'b0);
    req_mask = 4'b0010;
    drive(4'b0011, 4'hF, 1'b1, 8'd2);
    #1 chk("m_b2_rdy", 32'(bus.in_ready), 32'h2);
    tick();
    chk_out("m_b2", 1'b1, 32'h102, 1'b1, 2'd1, 1'b0, 1'b0);
    drive(4'b0011, 4'h0, 1'b1, 8'd0);
    tick();
    chk_out("m_rearb", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(4'b0011, 4'hF, 1'b1, 8'd3);
    tick();
    chk_out("m_p0", 1'b1, 32'h003, 1'b1, 2'd0, 1'b0, 1'b0);
    req_mask = 4'h0;
    drive(4'h0, 4'h0, 1'b1, 8'd0);
    tick();
    chk("m_drain_ov", 32'(bus.out_valid), 32'd0);

    // Stall: lane 2 sends A,B,C; downstream holds off for two cycles after A.
    drive(4'b0100, 4'h0, 1'b1, 8'h0A);
    tick();
    chk_out("s_arb", 1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 1'b0);
    drive(4'b0100, 4'h0, 1'b1, 8'h0A);
    #1 chk("s_a_rdy", 32'(bus.in_ready), 32'h4);
    tick();
    chk_out("s_a", 1'b1, 32'h20A, 1'b0, 2'd2, 1'b1, 1'b0);
    for (int s = 0; s < 2; s++) begin
      drive(4'b0100, 4'h0, 1'b0, 8'h0B);
      #1 chk($sformatf("s_stall%0d_rdy", s), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("s_stall%0d", s), 1'b1, 32'h20A, 1'b0, 2'd2, 1'b1, 1'b0);
    end
    drive(4'b0100, 4'h0, 1'b1, 8'h0B);
    #1 chk("s_b_rdy", 32'(bus.in_ready), 32'h4);
    tick();
    chk_out("s_b", 1'b1, 32'h20B, 1'b0, 2'd2, 1'b1, 1'b0);
    drive(4'b0100, 4'b0100, 1'b1, 8'h0C);
    tick();
    chk_out("s_c", 1'b1, 32'h20C, 1'b1, 2'd2, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 1'b1, 8'd0);
    tick();
    chk("s_drain_ov", 32'(bus.out_valid), 32'd0);

    // Watchdog: lane 3 streams without last; lane 1 waits and must win after the release.
    drive(4'b1010, 4'h0, 1'b1, 8'd0);
    tick();
    chk_out("t_arb", 1'b0, 32'h0, 1'b0, 2'd3, 1'b1, 1'b0);
    for (int b = 1; b <= 16; b++) begin
      drive(4'b1010, 4'h0, 1'b1, 8'(b));
      #1 chk($sformatf("t_b%0d_rdy", b), 32'(bus.in_ready), 32'h8);
      tick();
      chk_out($sformatf("t_b%0d", b), 1'b1, 32'h300 + 32'(b), 1'b0, 2'd3, (b < 16), (b == 16));
    end
    drive(4'b1010, 4'h0, 1'b1, 8'd17);
    #1 chk("t_idle_rdy", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("t_next", 1'b0, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0);
    drive(4'b1010, 4'b0010, 1'b1, 8'h11);
    tick();
    chk_out("t_p1", 1'b1, 32'h111, 1'b1, 2'd1, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 1'b1, 8'd0);
    tick();

    // Reset during beat 2 of a lane-2 packet, then lanes 0 and 3 compete.
    drive(4'b0100, 4'h0, 1'b1, 8'd0);
    tick();
    chk_out("r_arb", 1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 1'b0);
    drive(4'b0100, 4'h0, 1'b1, 8'd1);
    tick();
    chk_out("r_b1", 1'b1, 32'h201, 1'b0, 2'd2, 1'b1, 1'b0);
    drive(4'b0100, 4'h0, 1'b1, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_ov", 32'(bus.out_valid), 32'd0);
    chk("r_async_rdy", 32'(bus.in_ready), 32'd0);
    chk("r_async_busy", 32'(busy), 32'd0);
    chk("r_async_gnt", 32'(grant_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, 4'h0, 1'b1, 8'd1);
    tick();
    chk_out("r_rearb", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(4'b1001, 4'hF, 1'b1, 8'd3);
    tick();
    chk_out("r_p0", 1'b1, 32'h003, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 1'b1, 8'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_arb4x1.md
STREAM_ARB4X1 -- requirements
Module: stream_arb4x1

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of every data path.
REQ-002 Parameter: MAX_BEATS, default 16, maximum beats per packet before forced grant release (watchdog).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  4  per-requester beat valid.
REQ-006 in_data  input  DATA_WIDTH x [4] (unpacked array)  per-requester beat data.
REQ-007 in_last  input  4  per-requester end-of-packet flag.
REQ-008 in_ready  output  4  per-requester beat accepted when in_valid[i] && in_ready[i].
REQ-009 req_mask  input  4  1 = requester excluded from new arbitration; does not affect an already-granted packet.
REQ-010 out_valid  output  1  registered output beat valid.
REQ-011 out_data  output  DATA_WIDTH  registered output beat data.
REQ-012 out_last  output  1  registered output end-of-packet flag.
REQ-013 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 grant_sel  output  2  index of current grant; drives the shared 4:1 data select.
REQ-015 busy  output  1  1 while in BUSY state.
REQ-016 timeout  output  1  one-cycle pulse when the watchdog releases a grant.

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY.
REQ-018 IDLE: if any (in_valid & ~req_mask) bit is set, SHALL latch the winner into grant_sel and enter BUSY next cycle; otherwise stay IDLE.
REQ-019 Arbitration SHALL be round-robin: search from (rr_ptr+1) mod 4 upward with wrap; first eligible index wins.
REQ-020 in_ready SHALL be 0 in IDLE; in BUSY, in_ready[grant_sel] = (!out_valid || out_ready) and all other in_ready bits are 0.
REQ-021 An accepted beat SHALL appear on out_data/out_last with out_valid=1 exactly one cycle later (latency 1).
REQ-022 out_valid SHALL stay 1 and out_data/out_last stable until out_ready=1; a simultaneous accept-in/accept-out SHALL reload the register with no bubble.
REQ-023 With out_valid=1 and out_ready=1 and no new beat accepted, out_valid SHALL drop to 0 the next cycle.
REQ-024 Accepting a beat with in_last=1 SHALL return the FSM to IDLE next cycle and set rr_ptr = grant_sel.
REQ-025 A beat counter SHALL count accepted beats in BUSY, clearing on entry to BUSY.
REQ-026 If the counter reaches MAX_BEATS without a last beat, the FSM SHALL go to IDLE, pulse timeout for one cycle, and set rr_ptr = grant_sel; the already-accepted beats remain in flight unchanged.
REQ-027 Minimum inter-packet gap SHALL be one IDLE cycle (re-arbitration cycle); back-to-back packets from one requester are allowed only if it wins again.
REQ-028 req_mask changes during BUSY SHALL NOT revoke the current grant.
REQ-029 grant_sel SHALL hold its last value in IDLE until a new winner is latched.
REQ-030 Single-beat packet (in_last=1 on first beat) SHALL be legal and SHALL complete in one BUSY cycle when ready.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, rr_ptr=3, grant_sel=0, counter=0, out_valid=0, out_last=0, out_data=0, busy=0, timeout=0, in_ready=0.
REQ-032 Reset mid-packet SHALL discard the in-flight beat and grant; first arbitration after release SHALL start search at index 0.

Verification
REQ-033 All 4 valid continuously, 2-beat packets, out_ready=1 -> grants in order 0,1,2,3,0; each packet = IDLE cycle + 2 BUSY cycles.
REQ-034 Port 2 sends 3-beat packet 0xA,0xB,0xC; out_ready low for 2 cycles after first output -> out_data holds 0xA, in_ready[2]=0 during stall, final sequence 0xA,0xB,0xC with out_last only on 0xC.
REQ-035 req_mask=4'b0001, ports 0 and 1 valid -> port 1 granted; mask set to 4'b0010 mid-packet -> port 1 packet completes uninterrupted.
REQ-036 MAX_BEATS=16, port 3 streams 20 beats with no last -> timeout pulses once after 16th accepted beat, FSM returns to IDLE, next grant goes to next eligible port after 3.
REQ-037 Assert rst_n=0 during beat 2 of a 4-beat packet -> out_valid=0 and in_ready=0 immediately; after release with port 0 and 3 valid, port 0 granted first.
REQ-038 Single-beat packets from ports 1 and 3 only -> alternating 1,3,1,3, each output beat carrying out_last=1.
